// File: rtl/axil_rd_arbiter.sv
// axil_rd_arbiter: round-robin N-to-1 AXI-Lite read arbiter, one read outstanding, registered AR slice
module axil_rd_arbiter #(
  parameter int NUM_M = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int SEL_WIDTH = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_M*ADDR_WIDTH-1:0]        s_axil_araddr,
  input  logic [NUM_M*3-1:0]                 s_axil_arprot,
  input  logic [NUM_M-1:0]                   s_axil_arvalid,
  output logic [NUM_M-1:0]                   s_axil_arready,
  output logic [NUM_M*AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [NUM_M*2-1:0]                 s_axil_rresp,
  output logic [NUM_M-1:0]                   s_axil_rvalid,
  input  logic [NUM_M-1:0]                   s_axil_rready,
  output logic [ADDR_WIDTH-1:0]              m_axil_araddr,
  output logic [2:0]                         m_axil_arprot,
  output logic                               m_axil_arvalid,
  input  logic                               m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                         m_axil_rresp,
  input  logic                               m_axil_rvalid,
  output logic                               m_axil_rready
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t state, state_nxt;
  logic [SEL_WIDTH-1:0] grant, ptr, win;
  logic found, r_hs;
  // first requester at or after ptr, wrapping
  always_comb begin
    int idx;
    idx = 0;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = (int'(ptr) + k) % NUM_M;
      if (!found && s_axil_arvalid[idx]) begin
        found = 1'b1;
        win = SEL_WIDTH'(idx);
      end
    end
  end
  assign r_hs = (state == RESP) && m_axil_rvalid && s_axil_rready[grant];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (found ? ADDR : IDLE) :
                (state == ADDR) ? (m_axil_arready ? RESP : ADDR) :
                (r_hs ? IDLE : RESP);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant <= '0;
      ptr <= '0;
      m_axil_araddr <= '0;
      m_axil_arprot <= '0;
      m_axil_arvalid <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        grant <= win;
        m_axil_araddr <= s_axil_araddr[win*ADDR_WIDTH +: ADDR_WIDTH];
        m_axil_arprot <= s_axil_arprot[win*3 +: 3];
        m_axil_arvalid <= 1'b1;
      end
      if (state == ADDR && m_axil_arready) m_axil_arvalid <= 1'b0;
      if (r_hs) ptr <= (grant == SEL_WIDTH'(NUM_M-1)) ? '0 : grant + 1'b1;
    end
  always_comb begin
    s_axil_arready = '0;
    s_axil_rvalid = '0;
    s_axil_rdata = '0;
    s_axil_rresp = '0;
    if (state == IDLE && found) s_axil_arready[win] = 1'b1;
    if (state == RESP) begin
      s_axil_rvalid[grant] = m_axil_rvalid;
      s_axil_rdata[grant*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH] = m_axil_rdata;
      s_axil_rresp[grant*2 +: 2] = m_axil_rresp;
    end
  end
  assign m_axil_rready = (state == RESP) && s_axil_rready[grant];
endmodule

// File: tb/tb_axil_rd_arbiter.sv
// tb_axil_rd_arbiter: directed vector bench for the 2-master arbiter plus a 3-master rotation check
module tb_axil_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [63:0] s_araddr;
  logic [5:0]  s_arprot;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [3:0]  s_rresp;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arprot;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_rresp;
  axil_rd_arbiter #(.NUM_M(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid),
    .s_axil_arready(s_arready), .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
    .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid),
    .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
  );
  logic [95:0] s3_araddr, s3_rdata;
  logic [8:0]  s3_arprot;
  logic [2:0]  s3_arvalid, s3_arready, s3_rvalid, s3_rready;
  logic [5:0]  s3_rresp;
  logic [31:0] m3_araddr, m3_rdata;
  logic [2:0]  m3_arprot;
  logic        m3_arvalid, m3_arready, m3_rvalid, m3_rready;
  logic [1:0]  m3_rresp;
  axil_rd_arbiter #(.NUM_M(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(s3_araddr), .s_axil_arprot(s3_arprot), .s_axil_arvalid(s3_arvalid),
    .s_axil_arready(s3_arready), .s_axil_rdata(s3_rdata), .s_axil_rresp(s3_rresp),
    .s_axil_rvalid(s3_rvalid), .s_axil_rready(s3_rready),
    .m_axil_araddr(m3_araddr), .m_axil_arprot(m3_arprot), .m_axil_arvalid(m3_arvalid),
    .m_axil_arready(m3_arready), .m_axil_rdata(m3_rdata), .m_axil_rresp(m3_rresp),
    .m_axil_rvalid(m3_rvalid), .m_axil_rready(m3_rready)
  );
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [1:0]  valid;
    int          dly;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          g;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic txn(input vec_t v);
    logic [31:0] a;
    a = s_araddr[v.g*32 +: 32];
    s_arvalid = v.valid;
    m_arready = 1'b0;
    m_rvalid = 1'b0;
    s_rready = 2'b11;
    #1;
    chk("arready_accept", 64'(s_arready), 64'(1) << v.g);
    chk("rready_idle", 64'(m_rready), 64'd0);
    @(posedge clk); #1;
    chk("arvalid_set", 64'(m_arvalid), 64'd1);
    chk("araddr", 64'(m_araddr), 64'(a));
    chk("arprot", 64'(m_arprot), 64'(s_arprot[v.g*3 +: 3]));
    chk("arready_busy", 64'(s_arready), 64'd0);
    repeat (v.dly) begin
      @(posedge clk); #1;
      chk("arvalid_hold", 64'(m_arvalid), 64'd1);
      chk("araddr_hold", 64'(m_araddr), 64'(a));
    end
    m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0;
    chk("arvalid_clr", 64'(m_arvalid), 64'd0);
    m_rvalid = 1'b1;
    m_rdata = v.rdata;
    m_rresp = v.rresp;
    #1;
    chk("rvalid", 64'(s_rvalid), 64'(1) << v.g);
    chk("rdata", s_rdata, 64'(v.rdata) << (32*v.g));
    chk("rresp", 64'(s_rresp), 64'(v.rresp) << (2*v.g));
    chk("m_rready", 64'(m_rready), 64'd1);
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    m_rdata = '0;
    m_rresp = '0;
  endtask
  task automatic t3(input logic [2:0] mask, input int g);
    s3_arvalid = mask;
    m3_arready = 1'b1;
    m3_rvalid = 1'b1;
    m3_rdata = 32'h3300 + g;
    #1;
    chk("n3_arready", 64'(s3_arready), 64'(1) << g);
    @(posedge clk); #1;
    chk("n3_araddr", 64'(m3_araddr), 64'(s3_araddr[g*32 +: 32]));
    @(posedge clk); #1;
    chk("n3_rvalid", 64'(s3_rvalid), 64'(1) << g);
    chk("n3_rdata", 64'(s3_rdata[g*32 +: 32]), 64'(32'h3300 + g));
    @(posedge clk); #1;
    s3_arvalid = '0;
    m3_arready = 1'b0;
    m3_rvalid = 1'b0;
  endtask
  initial begin
    tv[0] = '{2'b10, 2, 32'hDEADBEEF, 2'b00, 1};
    tv[1] = '{2'b11, 0, 32'h11111111, 2'b00, 0};
    tv[2] = '{2'b11, 0, 32'h22222222, 2'b00, 1};
    tv[3] = '{2'b11, 0, 32'h33333333, 2'b10, 0};
    tv[4] = '{2'b01, 1, 32'h44444444, 2'b11, 0};
    tv[5] = '{2'b11, 0, 32'h55555555, 2'b01, 1};
    s_araddr = {32'h0000_1000, 32'h0000_0A00};
    s_arprot = {3'b101, 3'b010};
    s_arvalid = '0;
    s_rready = 2'b11;
    m_arready = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = '0;
    m_rresp = '0;
    s3_araddr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    s3_arprot = '0;
    s3_arvalid = '0;
    s3_rready = 3'b111;
    m3_arready = 1'b0;
    m3_rdata = '0;
    m3_rresp = '0;
    m3_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_araddr", 64'(m_araddr), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_arready", 64'(s_arready), 64'd0);
    chk("idle_rvalid", 64'(s_rvalid), 64'd0);
    chk("idle_rready", 64'(m_rready), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) txn(tv[i]);
    s_arvalid = 2'b01;
    m_arready = 1'b1;
    #1;
    chk("bp_arready", 64'(s_arready), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_arready = 1'b0;
    s_arvalid = '0;
    m_rvalid = 1'b1;
    m_rdata = 32'hCAFEF00D;
    m_rresp = 2'b00;
    s_rready = 2'b10;
    repeat (4) begin
      #1;
      chk("bp_rready", 64'(m_rready), 64'd0);
      chk("bp_rvalid", 64'(s_rvalid), 64'd1);
      chk("bp_rdata", s_rdata, 64'h0000_0000_CAFE_F00D);
      @(posedge clk); #1;
    end
    s_rready = 2'b11;
    #1;
    chk("bp_rready_hs", 64'(m_rready), 64'd1);
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    #1;
    chk("bp_done_rvalid", 64'(s_rvalid), 64'd0);
    chk("bp_done_rready", 64'(m_rready), 64'd0);
    s_arvalid = 2'b10;
    #1;
    chk("ra_arready", 64'(s_arready), 64'd2);
    @(posedge clk); #1;
    chk("ra_arvalid", 64'(m_arvalid), 64'd1);
    s_arvalid = '0;
    rst_n = 1'b0;
    #1;
    chk("ra_rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("ra_rst_araddr", 64'(m_araddr), 64'd0);
    #2;
    rst_n = 1'b1;
    txn('{2'b11, 0, 32'h66666666, 2'b00, 0});
    t3(3'b001, 0);
    t3(3'b101, 2);
    t3(3'b101, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
